// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one fixed-latency pipelined FP32 multiplier among
// N_REQ requesters. Round-robin issue, requester-ID tag pipeline, in-order
// first-word-fall-through response FIFO, and credit flow control so that the
// FIFO can never overflow.
// Optional build macro FPMUL_ARB_STATS_EN adds per-requester issue counters
// (issue_cnt) and a credit-stall counter (stall_cnt).
module fp_mul_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MUL_LAT    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_res,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data
`ifdef FPMUL_ARB_STATS_EN
    ,
    output logic [32*N_REQ-1:0]   issue_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ID_W:0] N_W     = (ID_W+1)'(N_REQ);
    localparam logic [IW:0]   DEPTH_U = (IW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [ID_W-1:0] rr_ptr;
    logic [IW-1:0]   inflight;
    logic [AW:0]     fifo_count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [ID_W+31:0] fifo_mem [FIFO_DEPTH];

    // Tag stage k holds the issue from k edges ago; stage MUL_LAT is
    // therefore valid in the same cycle the matching product sits on mul_res.
    logic            tag_v  [0:MUL_LAT];
    logic [ID_W-1:0] tag_id [0:MUL_LAT];

    logic            found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;
    logic [ID_W:0]   nxt_ptr;
    logic [IW:0]     used;
    logic            can_issue;
    logic            issue;
    logic            push;
    logic            pop;

    // Credits come from registered state only, so resp_ready never reaches req_ready.
    always_comb begin
        used      = (IW+1)'(inflight) + (IW+1)'(fifo_count);
        can_issue = (used < DEPTH_U);
    end

    // Round-robin search starting at rr_ptr, wrapping at N_REQ.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= N_W) cand = cand - N_W;
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    // Grant decode; held at zero while reset is asserted.
    always_comb begin
        issue     = rst_n & can_issue & found;
        req_ready = '0;
        if (issue) req_ready[grant_idx] = 1'b1;
        nxt_ptr = {1'b0, grant_idx} + (ID_W+1)'(1);
        if (nxt_ptr >= N_W) nxt_ptr = '0;
    end

    // FIFO status and fall-through head presentation (zero when empty).
    always_comb begin
        push       = tag_v[MUL_LAT];
        resp_valid = (fifo_count != '0);
        pop        = resp_valid & resp_ready;
        resp_id    = '0;
        resp_data  = '0;
        if (resp_valid) begin
            resp_id   = fifo_mem[rd_ptr][ID_W+31:32];
            resp_data = fifo_mem[rd_ptr][31:0];
        end
    end

    // Operand register and round-robin pointer advance on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a  <= '0;
            mul_b  <= '0;
            rr_ptr <= '0;
        end else if (issue) begin
            mul_a  <= req_a[{grant_idx, 5'd0} +: 32];
            mul_b  <= req_b[{grant_idx, 5'd0} +: 32];
            rr_ptr <= nxt_ptr[ID_W-1:0];
        end
    end

    // Tag pipeline shadows the multiplier so each product keeps its ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= MUL_LAT; s++) begin
                tag_v[s]  <= 1'b0;
                tag_id[s] <= '0;
            end
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= grant_idx;
            for (int s = 1; s <= MUL_LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    // In-flight count: up on issue, down when the product lands in the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide at any level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the head.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {tag_id[MUL_LAT], mul_res};
    end

    // Credits make this unreachable; it guards against a broken credit path.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push && !pop && fifo_count == DEPTH_C));

`ifdef FPMUL_ARB_STATS_EN
    // Per-requester issue counters and credit-stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (issue && grant_idx == ID_W'(i))
                    issue_cnt[32*i +: 32] <= issue_cnt[32*i +: 32] + 32'd1;
            end
            if ((|req_valid) && !issue && !can_issue)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a 3-stage FP32 multiplier model.
module tb_fp_mul_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [31:0]   mul_a, mul_b;
    logic [31:0]   mul_res;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [1:0]    resp_id;
    logic [31:0]   resp_data;
`ifdef FPMUL_ARB_STATS_EN
    logic [32*N-1:0] issue_cnt;
    logic [31:0]     stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Products of standard operands: requester i sends (i+1.0) * 2.0
    logic [31:0] exp_p [N] = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};

    fp_mul_arbiter #(.N_REQ(N), .MUL_LAT(3), .FIFO_DEPTH(4), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data)
`ifdef FPMUL_ARB_STATS_EN
        , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Truncating FP32 multiply for normal operands (exact for the values used).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (m[47]) begin
            e = e + 10'd1;
            return {s, e[7:0], m[46:24]};
        end
        return {s, e[7:0], m[45:23]};
    endfunction

    logic [31:0] p0, p1;
    always @(posedge clk) begin
        p0      <= fmul(mul_a, mul_b);
        p1      <= p0;
        mul_res <= p1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_std_ops();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'h3F80_0000 + (i == 0 ? 32'h0 : i == 1 ? 32'h0080_0000 :
                                                 i == 2 ? 32'h00C0_0000 : 32'h0100_0000);
            req_b[32*i +: 32] = 32'h4000_0000;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        tick();
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
        checks++; if (mul_a !== 32'h0) begin errors++; $display("FAIL rst_mul_a: got %h want 0", mul_a); end
        checks++; if (mul_b !== 32'h0) begin errors++; $display("FAIL rst_mul_b: got %h want 0", mul_b); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL rst_resp_id: got %0d want 0", resp_id); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_issue();
        do_reset();
        load_std_ops();
        req_a[64 +: 32] = 32'h3FC0_0000;
        req_b[64 +: 32] = 32'h4000_0000;
        resp_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (mul_a !== 32'h3FC0_0000) begin errors++; $display("FAIL single_mul_a: got %h want 3fc00000", mul_a); end
        checks++; if (mul_b !== 32'h4000_0000) begin errors++; $display("FAIL single_mul_b: got %h want 40000000", mul_b); end
        tick(); tick(); tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", resp_valid); end
        tick();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", resp_valid); end
        checks++; if (resp_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", resp_id); end
        checks++; if (resp_data !== 32'h4040_0000) begin errors++; $display("FAIL single_data: got %h want 40400000", resp_data); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", resp_valid); end
    endtask

    task automatic test_round_robin();
        int n_iss;
        int n_rsp;
        logic [3:0] exp_rdy;
        do_reset();
        load_std_ops();
        resp_ready = 1'b1;
        req_valid = 4'b1111;
        n_iss = 0;
        n_rsp = 0;
        for (int c = 0; c < 200 && n_rsp < 8; c++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                exp_rdy = 4'b0001 << (n_iss % 4);
                checks++;
                if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant: got %b want %b", req_ready, exp_rdy); end
                n_iss++;
            end
            if (resp_valid && resp_ready) begin
                checks++;
                if (resp_id !== 2'(n_rsp % 4) || resp_data !== exp_p[n_rsp % 4]) begin
                    errors++;
                    $display("FAIL rr_resp: got id %0d data %h want id %0d data %h",
                             resp_id, resp_data, n_rsp % 4, exp_p[n_rsp % 4]);
                end
                n_rsp++;
            end
            tick();
            if (n_iss >= 8) req_valid = '0;
        end
        checks++;
        if (n_rsp != 8) begin errors++; $display("FAIL rr_timeout: got %0d responses want 8", n_rsp); end
    endtask

    task automatic test_backpressure();
        int n_iss;
        do_reset();
        load_std_ops();
        resp_ready = 1'b0;
        req_valid = 4'b1111;
        n_iss = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready !== 4'b0000) n_iss++;
            tick();
        end
        checks++; if (n_iss != 4) begin errors++; $display("FAIL bp_issues: got %0d want 4", n_iss); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_blocked: got %b want 0000", req_ready); end
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== exp_p[0]) begin
            errors++; $display("FAIL bp_head: got v%b id %0d data %h want v1 id 0 data %h", resp_valid, resp_id, resp_data, exp_p[0]);
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_comb_path: got %b want 0000", req_ready); end
        tick();
        resp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_credit_grant: got %b want 0001", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_one_issue: got %b want 0000", req_ready); end
        checks++; if (resp_id !== 2'd1) begin errors++; $display("FAIL bp_next_head: got %0d want 1", resp_id); end
        n_iss = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (req_ready !== 4'b0000) n_iss++;
            tick();
        end
        checks++; if (n_iss != 0) begin errors++; $display("FAIL bp_extra_issue: got %0d want 0", n_iss); end
    endtask

    // Continues from the full FIFO left by test_backpressure (head id 1).
    task automatic test_full_fifo();
        int n;
        int e;
        resp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 8; c++) begin
            #1;
            if (resp_valid) begin
                e = (n + 1) % 4;
                checks++;
                if (resp_id !== 2'(e) || resp_data !== exp_p[e]) begin
                    errors++;
                    $display("FAIL full_resp: got id %0d data %h want id %0d data %h", resp_id, resp_data, e, exp_p[e]);
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 8) begin errors++; $display("FAIL full_timeout: got %0d responses want 8", n); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_flight();
        int seen;
        do_reset();
        load_std_ops();
        resp_ready = 1'b1;
        req_valid = 4'b1111;
        tick(); tick(); tick();
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_req_ready: got %b want 0000", req_ready); end
        checks++; if (mul_a !== 32'h0 || mul_b !== 32'h0) begin errors++; $display("FAIL mid_mul_ops: got %h %h want 0 0", mul_a, mul_b); end
        checks++; if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_data !== 32'h0) begin
            errors++; $display("FAIL mid_resp: got v%b id %0d data %h want all 0", resp_valid, resp_id, resp_data);
        end
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (resp_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_stale_resp: got %0d want 0", seen); end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
        req_valid = '0;
    endtask

`ifdef FPMUL_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        load_std_ops();
        resp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (issue_cnt[32*i +: 32] !== 32'd1) begin
                errors++; $display("FAIL stats_issue_%0d: got %0d want 1", i, issue_cnt[32*i +: 32]);
            end
        end
        checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL stats_stall: got %0d want 6", stall_cnt); end
        req_valid = '0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_issue();
        test_round_robin();
        test_backpressure();
        test_full_fifo();
        test_reset_mid_flight();
`ifdef FPMUL_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
